// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types, constants and access-legality rule for the APB register-file completer
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int DATA_W    = 8;
  localparam int RF_ADDR_W = 3;
  localparam int NUM_REGS  = 8;
  localparam logic [RF_ADDR_W-1:0] APB_REG_IDX = 3'd7;

  // Reads may target any of the eight registers; only register 7 accepts APB writes.
  // The address is taken zero-extended to 32 bits so the rule sees every upper bit.
  function automatic logic is_legal(input logic [31:0] addr, input logic write);
    if (write) begin
      return addr == {29'd0, APB_REG_IDX};
    end
    return addr < 32'(NUM_REGS);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// rtl/apb_wait_timer.sv - loadable down-counter that paces APB wait states
module apb_wait_timer #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic done_o,
  output logic next_zero_o
);

  localparam logic [3:0] LOAD_VAL = 4'(WAIT_CYCLES);

  logic [3:0] count_q, count_d;

  // Load takes priority; decrement stops at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = LOAD_VAL;
    end else if (dec_i && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o      = (count_q == 4'd0);
  // Lets the caller register its completion outputs one edge early.
  assign next_zero_o = (count_d == 4'd0);

endmodule

// File: rtl/apb_regfile_completer.sv
// rtl/apb_regfile_completer.sv - APB3 completer bridging the bus to the 8x8 register file
module apb_regfile_completer
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 8,   // up to 32 bits
  parameter int WAIT_CYCLES = 1    // 0..15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [ADDR_W-1:0]    paddr,
  input  logic [DATA_W-1:0]    pwdata,
  output logic [DATA_W-1:0]    prdata,
  output logic                 pready,
  output logic                 pslverr,
  output logic                 rf_write_en,
  output logic                 rf_apb_op,
  output logic [DATA_W-1:0]    rf_apb_data,
  output logic [RF_ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0]    rf_read_data
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic [DATA_W-1:0]   apb_data_q, apb_data_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic                write_en_q, write_en_d;

  logic                take_setup;
  logic                dec;
  logic                timer_done;
  logic                timer_next_zero;
  logic                legal;
  logic [ADDR_W-1:0]   cur_addr;
  logic                cur_write;
  logic [DATA_W-1:0]   cur_wdata;

  // A setup phase is only accepted from IDLE; a stray penable there is ignored.
  assign take_setup = (state_q == IDLE) && psel && !penable;
  // Count down only during a genuine access phase that has not yet completed.
  assign dec = (state_q == ACCESS) && psel && penable && !pready_q && !timer_done;

  // With zero wait states the transfer completes on the setup edge itself,
  // so the live bus values stand in for the not-yet-latched copies.
  assign cur_addr  = take_setup ? paddr  : addr_q;
  assign cur_write = take_setup ? pwrite : write_q;
  assign cur_wdata = take_setup ? pwdata : wdata_q;
  assign legal     = is_legal(32'(cur_addr), cur_write);

  apb_wait_timer #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_timer (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_i      (take_setup),
    .dec_i       (dec),
    .done_o      (timer_done),
    .next_zero_o (timer_next_zero)
  );

  // Next-state and next-output decode; outputs are nonzero only for the completion cycle.
  always_comb begin
    state_d    = state_q;
    pready_d   = (take_setup || dec) && timer_next_zero;
    pslverr_d  = pready_d && !legal;
    write_en_d = pready_d && legal && cur_write;
    apb_data_d = write_en_d ? cur_wdata : '0;
    prdata_d   = (pready_d && legal && !cur_write) ? rf_read_data : '0;
    unique case (state_q)
      IDLE:   if (take_setup) state_d = ACCESS;
      ACCESS: if (!psel || pready_q) state_d = IDLE;
    endcase
  end

  // Control state and the transfer attributes captured at setup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (take_setup) begin
        addr_q  <= paddr;
        write_q <= pwrite;
        wdata_q <= pwdata;
      end
    end
  end

  // Registered bus and register-file outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      write_en_q <= 1'b0;
      apb_data_q <= '0;
    end else begin
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      write_en_q <= write_en_d;
      apb_data_q <= apb_data_d;
    end
  end

  assign pready       = pready_q;
  assign pslverr      = pslverr_q;
  assign prdata       = prdata_q;
  assign rf_write_en  = write_en_q;
  assign rf_apb_op    = write_en_q;
  assign rf_apb_data  = apb_data_q;
  assign rf_read_addr = (state_q == IDLE) ? paddr[RF_ADDR_W-1:0] : addr_q[RF_ADDR_W-1:0];

endmodule

// File: doc/apb_regfile_completer.md
# apb_regfile_completer

APB3 completer that connects the I2C controller's 8x8-bit register file to the system APB bus. It decodes APB transfers, drives the register file's APB write path (write enable, APB-op select, APB data) for writes to register 7, and returns register contents over PRDATA for reads of registers 0-7. It inserts a parameterised number of wait states and flags illegal accesses with PSLVERR.

## Interface
Parameters:
- ADDR_W, 8, APB address width; only paddr[2:0] selects a register.
- WAIT_CYCLES, 1, wait states per transfer (0..15); 0 means zero-wait.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  byte address.
- pwdata  in  8  write data.
- prdata  out  8  read data; valid only while pready=1.
- pready  out  1  transfer-complete strobe.
- pslverr  out  1  error response; valid only while pready=1.
- rf_write_en  out  1  register-file write enable.
- rf_apb_op  out  1  register-file APB-op select (forces target register 7).
- rf_apb_data  out  8  register-file APB write data.
- rf_read_addr  out  3  register-file read address.
- rf_read_data  in  8  register-file read data (combinational from rf_read_addr).

## Operation
- States: IDLE, ACCESS.
- IDLE: on psel=1 and penable=0 (setup phase): latch paddr, pwrite and pwdata; load wait counter with WAIT_CYCLES; go to ACCESS. penable=1 without a preceding setup phase is ignored.
- ACCESS: while psel=1 and penable=1, decrement the counter each cycle until 0. Completion cycle: counter 0, so pready=1 for exactly one cycle. Next state is IDLE. A setup phase in the following cycle is then decoded normally, giving back-to-back transfers.
- Abort: psel=0 while in ACCESS returns the block to IDLE with no write, no pready and no pslverr.
- Legality:
  - Read is legal when paddr < 8.
  - Write is legal only when paddr == 7.
  - All other accesses complete with pslverr=1, prdata=0 and no register-file write.
- Legal write: rf_write_en=1, rf_apb_op=1 and rf_apb_data=latched pwdata in the completion cycle only. The register file captures the data at the edge that ends the transfer.
- Legal read: prdata=rf_read_data[latched addr], sampled on the edge that raises pready.
- rf_read_addr = paddr[2:0] in IDLE; latched address otherwise.
- Reset (asserted at any time, including mid-transfer):
  - state goes to IDLE and the counter to 0.
  - prdata, pready, pslverr, rf_write_en, rf_apb_op and rf_apb_data are all 0.
  - An in-flight write is dropped.

## Timing
- pready, pslverr, prdata, rf_write_en, rf_apb_op and rf_apb_data are registered outputs.
- Setup sampled at edge E0. pready is high in cycle E0+1+WAIT_CYCLES, for one cycle.
  - WAIT_CYCLES=0: pready is high in the first access cycle.
  - WAIT_CYCLES=1 (default): one wait cycle.
- Outside the completion cycle: pready, pslverr and rf_write_en are 0, and prdata is 8'h00.
- Write latency: register 7 holds the new value from the edge ending the completion cycle.
- Read-after-write to register 7 in the next transfer returns the new value.
- No stall on the regfile side; the regfile read path is combinational and must settle within one clk.

## Structure
- Shared package apb_pkg holds:
  - enum state_t {IDLE, ACCESS};
  - DATA_W=8, RF_ADDR_W=3, APB_REG_IDX=3'd7;
  - function is_legal(addr, write).
- One natural sub-module: apb_wait_timer, a loadable down-counter with a done flag, parameterised by WAIT_CYCLES.
- Top level apb_regfile_completer instantiates apb_wait_timer and connects to regfile ports reg_write_en / apb_op / apb_data / reg1_read_addr / reg1_read_data.

## Test plan
- Reset mid-ACCESS of write 8'hA5 to addr 7: all outputs 0, rf_write_en never pulses, regfile reg[7] stays 8'h00.
- WAIT_CYCLES=1, write 8'h3C to addr 7, then read addr 7: pready high exactly at E0+2 both times; rf_write_en a single cycle; prdata=8'h3C, pslverr=0.
- Write 8'h11 to addr 2: pslverr=1 with pready, rf_write_en stays 0, reg[2] unchanged.
- Read addr 8'h09: pslverr=1, prdata=8'h00.
- WAIT_CYCLES=0, back-to-back read addr 0 then read addr 7 (after reg[7]=8'hF0): pready in each first access cycle, prdata 8'h00 then 8'hF0.
- psel dropped during a wait cycle of a write 8'h55 to addr 7: no pready, reg[7] unchanged; a following legal read completes normally.
